// File: rtl/ram_pkg.sv
// Shared constants and the masked-merge helper for the register bank.
package ram_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_DEPTH = 4;

   // Widest word the merge helper supports.
   localparam int unsigned MAX_W = 64;

   // Keep old bits where mask is 0 and take data bits where mask is 1.
   function automatic logic [MAX_W-1:0] merge_word(
      input logic [MAX_W-1:0] old_w,
      input logic [MAX_W-1:0] data,
      input logic [MAX_W-1:0] mask
   );
      return (old_w & ~mask) | (data & mask);
   endfunction

endpackage

// File: rtl/reg_word.sv
// One storage row: WIDTH flops plus a written flag, with masked load and clear.
module reg_word
   import ram_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             i_clear,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_data,
   input  logic [WIDTH-1:0] i_mask,
   output logic [WIDTH-1:0] o_word_nxt_c,
   output logic             o_flag_nxt_c
);

   logic [WIDTH-1:0] r_word;
   logic             r_flag;
   logic [WIDTH-1:0] w_word_nxt;
   logic             w_flag_nxt;

   // Post-clear/post-write value; also exposed for write-first reads.
   always_comb begin
      w_word_nxt = r_word;
      w_flag_nxt = r_flag;
      if (i_clear) begin
         w_word_nxt = '0;
         w_flag_nxt = 1'b0;
      end else if (i_we && (i_mask != '0)) begin
         w_word_nxt = WIDTH'(merge_word(MAX_W'(r_word), MAX_W'(i_data), MAX_W'(i_mask)));
         w_flag_nxt = 1'b1;
      end
   end

   // Row state register with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_word <= '0;
         r_flag <= 1'b0;
      end else begin
         r_word <= w_word_nxt;
         r_flag <= w_flag_nxt;
      end
   end

   assign o_word_nxt_c = w_word_nxt;
   assign o_flag_nxt_c = w_flag_nxt;

endmodule

// File: rtl/reg_word_bank.sv
// DEPTH x WIDTH register bank: masked write port, registered write-first read port.
module reg_word_bank
   import ram_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Clear,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [WIDTH-1:0]  WrData,
   input  logic [WIDTH-1:0]  WrMask,
   input  logic              RdEn,
   input  logic [ADDR_W-1:0] RdAddr,
   output logic [WIDTH-1:0]  RdData,
   output logic              RdValid,
   output logic              RdHit
);

   logic [WIDTH-1:0] w_word_nxt [DEPTH];
   logic             w_flag_nxt [DEPTH];
   logic             w_we       [DEPTH];
   logic [WIDTH-1:0] w_rd_word;
   logic             w_rd_flag;

   logic [WIDTH-1:0] r_rd_data;
   logic             r_rd_valid;
   logic             r_rd_hit;

   // Row array; an out-of-range write address matches no row and is ignored.
   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      assign w_we[g] = WrEn && (WrAddr == ADDR_W'(g));

      reg_word #(
         .WIDTH (WIDTH)
      ) u_row (
         .Clk          (Clk),
         .Reset        (Reset),
         .i_clear      (Clear),
         .i_we         (w_we[g]),
         .i_data       (WrData),
         .i_mask       (WrMask),
         .o_word_nxt_c (w_word_nxt[g]),
         .o_flag_nxt_c (w_flag_nxt[g])
      );
   end

   // Read mux over post-write state; out-of-range reads return zero/miss.
   always_comb begin
      w_rd_word = '0;
      w_rd_flag = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (RdAddr == ADDR_W'(i)) begin
            w_rd_word = w_word_nxt[i];
            w_rd_flag = w_flag_nxt[i];
         end
      end
   end

   // Read output registers; data and hit hold when no read is issued.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
      end else begin
         r_rd_valid <= RdEn;
         if (RdEn) begin
            r_rd_data <= w_rd_word;
            r_rd_hit  <= w_rd_flag;
         end
      end
   end

   assign RdData  = r_rd_data;
   assign RdValid = r_rd_valid;
   assign RdHit   = r_rd_hit;

endmodule

// File: tb/tb_reg_word_bank.sv
// Scoreboard bench for reg_word_bank: a DEPTH=4 and a DEPTH=5 instance share stimulus.
module tb_reg_word_bank;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic       h;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, clr, we, re;
   logic [2:0] wa, ra;
   logic [7:0] wd, wm;

   logic [7:0] rd4, rd5;
   logic       v4, v5, h4, h5;

   int n_checks = 0;
   int n_errors = 0;

   exp_t q4[$];
   exp_t q5[$];

   // Reference state: model index 0 is the DEPTH=4 bank, index 1 the DEPTH=5 bank.
   logic [7:0] mem    [2][5];
   logic       flg    [2][5];
   logic [7:0] last_d [2];
   logic       last_h [2];

   always #5 clk = ~clk;

   reg_word_bank #(.WIDTH(8), .DEPTH(4)) u4 (
      .Clk(clk), .Reset(rst), .Clear(clr),
      .WrEn(we), .WrAddr(wa[1:0]), .WrData(wd), .WrMask(wm),
      .RdEn(re), .RdAddr(ra[1:0]),
      .RdData(rd4), .RdValid(v4), .RdHit(h4)
   );

   reg_word_bank #(.WIDTH(8), .DEPTH(5)) u5 (
      .Clk(clk), .Reset(rst), .Clear(clr),
      .WrEn(we), .WrAddr(wa), .WrData(wd), .WrMask(wm),
      .RdEn(re), .RdAddr(ra),
      .RdData(rd5), .RdValid(v5), .RdHit(h5)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model of one clock edge for one bank.
   task automatic model(input int k, input int depth, input int waddr, input int raddr,
                        output exp_t e);
      if (rst) begin
         for (int i = 0; i < 5; i++) begin
            mem[k][i] = 8'h00;
            flg[k][i] = 1'b0;
         end
         last_d[k] = 8'h00;
         last_h[k] = 1'b0;
         e = '{v: 1'b0, d: 8'h00, h: 1'b0};
         return;
      end
      if (clr) begin
         for (int i = 0; i < 5; i++) begin
            mem[k][i] = 8'h00;
            flg[k][i] = 1'b0;
         end
      end else if (we && waddr < depth && wm != 8'h00) begin
         mem[k][waddr] = (mem[k][waddr] & ~wm) | (wd & wm);
         flg[k][waddr] = 1'b1;
      end
      if (re) begin
         last_d[k] = (raddr < depth) ? mem[k][raddr] : 8'h00;
         last_h[k] = (raddr < depth) ? flg[k][raddr] : 1'b0;
      end
      e = '{v: re, d: last_d[k], h: last_h[k]};
   endtask

   // Apply one cycle of stimulus, advance the model, push expectations.
   task automatic cycle(input logic i_rst, input logic i_clr, input logic i_we,
                        input logic [2:0] i_wa, input logic [7:0] i_wd, input logic [7:0] i_wm,
                        input logic i_re, input logic [2:0] i_ra);
      exp_t e;
      rst = i_rst; clr = i_clr; we = i_we; wa = i_wa; wd = i_wd; wm = i_wm;
      re = i_re; ra = i_ra;
      @(posedge clk);
      model(0, 4, int'(i_wa[1:0]), int'(i_ra[1:0]), e);
      q4.push_back(e);
      model(1, 5, int'(i_wa), int'(i_ra), e);
      q5.push_back(e);
      #1;
   endtask

   task automatic rd(input logic [2:0] a);
      cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, a);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [7:0] m);
      cycle(1'b0, 1'b0, 1'b1, a, d, m, 1'b0, 3'd0);
   endtask

   // Monitor: pop one expectation per cycle and compare each bank's outputs.
   always @(negedge clk) begin
      exp_t e;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         chk("d4_valid", int'(v4), int'(e.v));
         chk("d4_data", int'(rd4), int'(e.d));
         chk("d4_hit", int'(h4), int'(e.h));
      end
      if (q5.size() > 0) begin
         e = q5.pop_front();
         chk("d5_valid", int'(v5), int'(e.v));
         chk("d5_data", int'(rd5), int'(e.d));
         chk("d5_hit", int'(h5), int'(e.h));
      end
   end

   initial begin
      rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
      wa = 3'd0; ra = 3'd0; wd = 8'h00; wm = 8'h00;

      cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
      cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);

      // Reset contents read back as zero / miss.
      for (int a = 0; a < 4; a++) rd(3'(a));

      // Full write then partial-mask overwrite.
      wr(3'd2, 8'hA5, 8'hFF);
      rd(3'd2);
      rd(3'd1);
      wr(3'd2, 8'h0F, 8'hF0);
      rd(3'd2);
      wr(3'd3, 8'hEE, 8'h00);
      rd(3'd3);

      // Write-first same-address read, then Clear beating write and read.
      cycle(1'b0, 1'b0, 1'b1, 3'd1, 8'h3C, 8'hFF, 1'b1, 3'd1);
      cycle(1'b0, 1'b1, 1'b1, 3'd1, 8'h3C, 8'hFF, 1'b1, 3'd1);
      rd(3'd2);

      // Reset overrides concurrent write and read.
      wr(3'd0, 8'h11, 8'hFF);
      cycle(1'b1, 1'b0, 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1, 3'd0);
      rd(3'd0);

      // Out-of-range write and read on the DEPTH=5 bank.
      wr(3'd6, 8'h77, 8'hFF);
      rd(3'd6);
      for (int a = 0; a < 5; a++) rd(3'(a));

      // Idle cycle: outputs hold, then eight back-to-back reads.
      cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
      for (int a = 0; a < 8; a++) rd(3'(a));

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
               1'($urandom), 3'($urandom), 8'($urandom),
               ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
               1'($urandom), 3'($urandom));
      end

      cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
      @(negedge clk);
      #1;
      if (q4.size() != 0 || q5.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d/%0d expectations left unchecked", q4.size(), q5.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
